// File: rtl/lsu_queued.sv
`default_nettype none
// ============================================================================
// Module   : lsu_queued
// Brief    : In-order load/store unit with an issue FIFO, one outstanding
//            dmem access, byte-lane alignment and CDB broadcast.
// Revision : 1.0
// ============================================================================
module lsu_queued #(
    parameter int TAG_W  = 4,
    parameter int QDEPTH = 4,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_req,
    output logic              iss_rdy,
    input  logic              iss_store,
    input  logic [2:0]        iss_funct3,
    input  logic [TAG_W-1:0]  iss_tag,
    input  logic [XLEN-1:0]   iss_src1,
    input  logic [XLEN-1:0]   iss_src2,
    input  logic [11:0]       iss_offset,
    input  logic              flush,
    output logic              cdb_req,
    input  logic              cdb_rdy,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [XLEN-1:0]   cdb_wdata,
    output logic              cdb_exc,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [3:0]        dmem_rmask,
    output logic [3:0]        dmem_wmask,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_resp
);

    localparam int C_PTR_W = $clog2(QDEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_CDB      = 2'd2,
        S_DRAIN    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic               r_q_store  [QDEPTH];
    logic [2:0]         r_q_funct3 [QDEPTH];
    logic [TAG_W-1:0]   r_q_tag    [QDEPTH];
    logic [XLEN-1:0]    r_q_addr   [QDEPTH];
    logic [XLEN-1:0]    r_q_data   [QDEPTH];

    logic [C_PTR_W-1:0] r_head;
    logic [C_PTR_W-1:0] r_tail;
    logic [C_CNT_W-1:0] r_count;

    logic [TAG_W-1:0]   r_cdb_tag;
    logic [XLEN-1:0]    r_cdb_wdata;
    logic               r_cdb_exc;

    logic               w_enq;
    logic               w_pop;
    logic               w_cap;
    logic               w_cap_exc;
    logic               w_issue;
    logic               w_nonempty;
    logic [XLEN-1:0]    w_eff_addr;

    logic               w_h_store;
    logic [2:0]         w_h_funct3;
    logic [TAG_W-1:0]   w_h_tag;
    logic [XLEN-1:0]    w_h_addr;
    logic [XLEN-1:0]    w_h_data;
    logic [1:0]         w_h_lane;
    logic               w_h_mis;
    logic [3:0]         w_h_mask;
    logic [XLEN-1:0]    w_shifted;
    logic [XLEN-1:0]    w_load_ext;
    logic [XLEN-1:0]    w_result;

    // ------------------------------------------------------------------
    // Issue side
    // ------------------------------------------------------------------
    assign iss_rdy    = (r_count != C_CNT_W'(QDEPTH));
    assign w_enq      = iss_req && iss_rdy && !flush;
    assign w_nonempty = (r_count != '0);
    assign w_eff_addr = iss_src1 + {{(XLEN-12){iss_offset[11]}}, iss_offset};

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_store[r_tail]  <= iss_store;
            r_q_funct3[r_tail] <= iss_funct3;
            r_q_tag[r_tail]    <= iss_tag;
            r_q_addr[r_tail]   <= w_eff_addr;
            r_q_data[r_tail]   <= iss_src2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + C_PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + C_PTR_W'(1);
            end
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + C_CNT_W'(1);
                2'b01:   r_count <= r_count - C_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Head entry decode
    // ------------------------------------------------------------------
    assign w_h_store  = r_q_store[r_head];
    assign w_h_funct3 = r_q_funct3[r_head];
    assign w_h_tag    = r_q_tag[r_head];
    assign w_h_addr   = r_q_addr[r_head];
    assign w_h_data   = r_q_data[r_head];
    assign w_h_lane   = w_h_addr[1:0];

    assign w_h_mis = ((w_h_funct3[1:0] == 2'b01) && w_h_lane[0]) ||
                     ((w_h_funct3[1:0] == 2'b10) && (w_h_lane != 2'b00));

    always_comb begin
        w_h_mask = 4'b1111;
        case (w_h_funct3[1:0])
            2'b00:   w_h_mask = 4'b0001 << w_h_lane;
            2'b01:   w_h_mask = 4'b0011 << {w_h_lane[1], 1'b0};
            default: w_h_mask = 4'b1111;
        endcase
    end

    // The request is combinational from the head so it lasts exactly the
    // one IDLE cycle before the FSM moves to MEM_WAIT.
    assign w_issue    = (r_state == S_IDLE) && w_nonempty && !w_h_mis;
    assign dmem_addr  = w_issue ? {w_h_addr[XLEN-1:2], 2'b00} : '0;
    assign dmem_rmask = (w_issue && !w_h_store) ? w_h_mask : 4'b0000;
    assign dmem_wmask = (w_issue &&  w_h_store) ? w_h_mask : 4'b0000;
    assign dmem_wdata = (w_issue &&  w_h_store) ? (w_h_data << {w_h_lane, 3'b000}) : '0;

    // ------------------------------------------------------------------
    // Load data alignment and extension
    // ------------------------------------------------------------------
    assign w_shifted = dmem_rdata >> {w_h_lane, 3'b000};

    always_comb begin
        w_load_ext = w_shifted;
        case (w_h_funct3)
            3'b000:  w_load_ext = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
            3'b001:  w_load_ext = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load_ext = {{(XLEN-8){1'b0}},           w_shifted[7:0]};
            3'b101:  w_load_ext = {{(XLEN-16){1'b0}},          w_shifted[15:0]};
            default: w_load_ext = w_shifted;
        endcase
    end

    assign w_result = w_h_store ? '0 : w_load_ext;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_cap        = 1'b0;
        w_cap_exc    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (flush) begin
                    w_next_state = w_issue ? S_DRAIN : S_IDLE;
                end else if (w_nonempty) begin
                    if (w_h_mis) begin
                        w_cap        = 1'b1;
                        w_cap_exc    = 1'b1;
                        w_next_state = S_CDB;
                    end else begin
                        w_next_state = S_MEM_WAIT;
                    end
                end
            end
            S_MEM_WAIT: begin
                // A flush coinciding with the response has nothing left to drain.
                if (dmem_resp) begin
                    if (flush) begin
                        w_next_state = S_IDLE;
                    end else begin
                        w_cap        = 1'b1;
                        w_next_state = S_CDB;
                    end
                end else if (flush) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_CDB: begin
                if (flush) begin
                    w_next_state = S_IDLE;
                end else if (cdb_rdy) begin
                    w_pop        = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (dmem_resp) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // CDB result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cdb_tag   <= '0;
            r_cdb_wdata <= '0;
            r_cdb_exc   <= 1'b0;
        end else if (w_cap) begin
            r_cdb_tag   <= w_h_tag;
            r_cdb_wdata <= w_cap_exc ? '0 : w_result;
            r_cdb_exc   <= w_cap_exc;
        end
    end

    assign cdb_req   = (r_state == S_CDB);
    assign cdb_tag   = cdb_req ? r_cdb_tag   : '0;
    assign cdb_wdata = cdb_req ? r_cdb_wdata : '0;
    assign cdb_exc   = cdb_req && r_cdb_exc;

endmodule
`default_nettype wire
